// File: rtl/idct_pkg.sv
// idct_pkg: shared types and constants for the sequential 8x8 IDCT.
//   state_e  : block controller states
//   BLK/N    : block size (64 samples) and transform length (8)
//   FRAC     : fractional bits of the cosine table (Q8)
//   IDCT_A   : A[k][n] = trunc(256*alpha(k)*cos((2n+1)k*pi/16)), 10-bit signed
package idct_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam int BLK  = 64;
  localparam int N    = 8;
  localparam int FRAC = 8;

  localparam logic signed [9:0] IDCT_A [0:7][0:7] = '{
    '{ 10'sd90,   10'sd90,   10'sd90,   10'sd90,   10'sd90,   10'sd90,   10'sd90,   10'sd90 },
    '{ 10'sd125,  10'sd106,  10'sd71,   10'sd24,  -10'sd24,  -10'sd71,  -10'sd106, -10'sd125 },
    '{ 10'sd118,  10'sd48,  -10'sd48,  -10'sd118, -10'sd118, -10'sd48,   10'sd48,   10'sd118 },
    '{ 10'sd106, -10'sd24,  -10'sd125, -10'sd71,   10'sd71,   10'sd125,  10'sd24,  -10'sd106 },
    '{ 10'sd90,  -10'sd90,  -10'sd90,   10'sd90,   10'sd90,  -10'sd90,  -10'sd90,   10'sd90 },
    '{ 10'sd71,  -10'sd125,  10'sd24,   10'sd106, -10'sd106, -10'sd24,   10'sd125, -10'sd71 },
    '{ 10'sd48,  -10'sd118,  10'sd118, -10'sd48,  -10'sd48,   10'sd118, -10'sd118,  10'sd48 },
    '{ 10'sd24,  -10'sd71,   10'sd106, -10'sd125,  10'sd125, -10'sd106,  10'sd71,  -10'sd24 }
  };

endpackage

// File: rtl/idct_8x8_seq_cos_rom.sv
// idct_cos_rom: combinational lookup into the Q8 IDCT cosine table.
//   k    : frequency index
//   n    : spatial index
//   coef : A[k][n], 10-bit signed
module idct_cos_rom
  import idct_pkg::*;
(
  input  logic [2:0] k,
  input  logic [2:0] n,
  output logic [9:0] coef
);

  assign coef = IDCT_A[k][n];

endmodule

// File: rtl/idct_8x8_seq.sv
// idct_8x8_seq: sequential two-pass 8x8 inverse DCT with one shared MAC.
//   clk, reset           : clock, async active-high reset
//   in_valid/in_ready    : coefficient stream, raster order X[u][v]
//   in_coef              : signed coefficient
//   out_valid/out_ready  : pixel stream, raster order P[y][x]
//   out_pixel, out_last  : unsigned pixel, high on pixel 63
//   busy                 : high while ROW, COL or OUT
//
// state | meaning
// LOAD  | accept 64 coefficients into coef_mem
// ROW   | pass 1, T[u][x] = sum_v A[v][x]*X[u][v] -> t_mem
// COL   | pass 2, P[y][x] = sum_u A[u][y]*T[u][x] -> coef_mem (pixels)
// OUT   | stream 64 pixels from coef_mem
module idct_8x8_seq
  import idct_pkg::*;
#(
  parameter int COEF_W      = 12,
  parameter int ACC_W       = 32,
  parameter int LEVEL_SHIFT = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_pixel,
  output logic                     out_last,
  output logic                     busy
);

  state_e                  state_q, state_d;
  logic [5:0]              idx_q, idx_d;
  logic [8:0]              cnt_q, cnt_d;
  logic [5:0]              oidx_q, oidx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;
  logic [7:0]              out_pixel_q, out_pixel_d;

  // coef_mem holds X during LOAD/ROW and is overwritten with pixels in COL;
  // COL only reads t_mem, so the reuse never races a pending read.
  logic [15:0] coef_mem_q [0:BLK-1];
  logic [15:0] t_mem_q    [0:BLK-1];

  logic        cm_we, tm_we;
  logic [5:0]  cm_waddr, tm_waddr;
  logic [15:0] cm_wdata, tm_wdata;

  logic [2:0]  rom_k, rom_n;
  logic [9:0]  rom_coef;
  logic [15:0] samp;

  logic signed [ACC_W-1:0] cos_ext, samp_ext, prod, sum, rnd, pshift;
  logic [15:0] t_sat;
  logic [7:0]  pix;
  logic        last_mac, end_pass;
  logic [5:0]  oidx_nx;

  idct_cos_rom u_rom (.k(rom_k), .n(rom_n), .coef(rom_coef));

  // cnt = {out_hi, out_lo, k}: the low three bits walk the summation index.
  always_comb begin
    rom_k = cnt_q[2:0];
    if (state_q == ST_COL) begin
      rom_n = cnt_q[8:6];
      samp  = t_mem_q[{cnt_q[2:0], cnt_q[5:3]}];
    end else begin
      rom_n = cnt_q[5:3];
      samp  = coef_mem_q[{cnt_q[8:6], cnt_q[2:0]}];
    end
  end

  assign cos_ext  = {{(ACC_W-10){rom_coef[9]}}, rom_coef};
  assign samp_ext = {{(ACC_W-16){samp[15]}}, samp};
  assign prod     = cos_ext * samp_ext;
  assign sum      = acc_q + prod;
  assign rnd      = (sum + ACC_W'(1 << (FRAC-1))) >>> FRAC;
  assign pshift   = rnd + ACC_W'(LEVEL_SHIFT);
  assign last_mac = (cnt_q[2:0] == 3'(N-1));
  assign end_pass = (cnt_q == 9'(BLK*N-1));
  assign oidx_nx  = oidx_q + 6'd1;

  always_comb begin
    if (rnd > ACC_W'(32767))       t_sat = 16'h7fff;
    else if (rnd < ACC_W'(-32768)) t_sat = 16'h8000;
    else                           t_sat = rnd[15:0];
    if (pshift < 0)                pix = 8'd0;
    else if (pshift > ACC_W'(255)) pix = 8'd255;
    else                           pix = pshift[7:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    oidx_d      = oidx_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    out_pixel_d = out_pixel_q;
    cm_we       = 1'b0;
    cm_waddr    = idx_q;
    cm_wdata    = {{(16-COEF_W){in_coef[COEF_W-1]}}, in_coef};
    tm_we       = 1'b0;
    tm_waddr    = cnt_q[8:3];
    tm_wdata    = t_sat;
    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          cm_we = 1'b1;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'(BLK-1)) begin
            state_d    = ST_ROW;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
            cnt_d      = '0;
            acc_d      = '0;
          end
        end
      end
      ST_ROW: begin
        acc_d = last_mac ? '0 : sum;
        tm_we = last_mac;
        cnt_d = cnt_q + 9'd1;
        if (end_pass) state_d = ST_COL;
      end
      ST_COL: begin
        acc_d    = last_mac ? '0 : sum;
        cm_we    = last_mac;
        cm_waddr = cnt_q[8:3];
        cm_wdata = {8'h00, pix};
        cnt_d    = cnt_q + 9'd1;
        if (end_pass) begin
          state_d = ST_OUT;
          oidx_d  = '0;
        end
      end
      ST_OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_pixel_d = coef_mem_q[oidx_q][7:0];
          out_last_d  = (oidx_q == 6'(BLK-1));
        end else if (out_ready) begin
          if (out_last_q) begin
            state_d     = ST_LOAD;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            oidx_d      = '0;
            idx_d       = '0;
          end else begin
            oidx_d      = oidx_nx;
            out_pixel_d = coef_mem_q[oidx_nx][7:0];
            out_last_d  = (oidx_nx == 6'(BLK-1));
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      oidx_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      oidx_q      <= oidx_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cm_we) coef_mem_q[cm_waddr] <= cm_wdata;
    if (tm_we) t_mem_q[tm_waddr]    <= tm_wdata;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_idct_8x8_seq.sv
// tb_idct_8x8_seq: directed bench for idct_8x8_seq with hand-derived pixels.
module tb_idct_8x8_seq;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [11:0] in_coef = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        out_pixel;
  logic              out_last;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [11:0] blk     [64];
  logic [7:0]         exp_pix [64];
  logic [7:0]         got     [64];
  logic               got_last[64];

  // AC X[0][1]=256: T[0][x]=A[1][x], pixel = ((90*A[1][x]+128)>>>8)+128
  logic [7:0] ac_col [8] = '{8'd172, 8'd165, 8'd153, 8'd136, 8'd120, 8'd103, 8'd91, 8'd84};

  idct_8x8_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_blk(input int idx, input int val);
    for (int i = 0; i < 64; i++) blk[i] = '0;
    blk[idx] = 12'(val);
  endtask

  task automatic send_block(input string tag);
    int not_ready;
    not_ready = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_coef  = blk[i];
      if (in_ready !== 1'b1) not_ready++;
      cyc();
    end
    in_valid = 1'b0;
    check({tag, " in_ready during load"}, not_ready, 0);
    check({tag, " in_ready drop"}, in_ready, 0);
    check({tag, " busy after load"}, busy, 1);
  endtask

  task automatic wait_out(input string tag, input bit junk);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 3000) begin
      in_valid = junk;
      in_coef  = 12'($urandom);
      cyc();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, lat, 1025);
  endtask

  task automatic recv_block(input string tag, input bit bp);
    int  n, ir_high, unstable;
    bit  r, stalled;
    logic [7:0] held;
    n = 0; ir_high = 0; unstable = 0; stalled = 0; held = '0;
    for (int c = 0; c < 3000 && n < 64; c++) begin
      if (stalled && (out_valid !== 1'b1 || out_pixel !== held)) unstable++;
      if (in_ready !== 1'b0) ir_high++;
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        got[n]      = out_pixel;
        got_last[n] = out_last;
        n++;
      end
      stalled = (out_valid === 1'b1) && !r;
      held    = out_pixel;
      cyc();
    end
    out_ready = 1'b0;
    check({tag, " pixel count"}, n, 64);
    check({tag, " stall stability"}, unstable, 0);
    check({tag, " in_ready low in out"}, ir_high, 0);
    check({tag, " out_valid after last"}, out_valid, 0);
    check({tag, " in_ready after last"}, in_ready, 1);
    check({tag, " busy after last"}, busy, 0);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s pixel[%0d]", tag, i), got[i], exp_pix[i]);
      check($sformatf("%s last[%0d]", tag, i), got_last[i], (i == 63) ? 1 : 0);
    end
  endtask

  task automatic run_block(input string tag, input bit bp, input bit junk);
    send_block(tag);
    wait_out(tag, junk);
    recv_block(tag, bp);
  endtask

  initial begin
    #1;
    repeat (3) cyc();
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset busy", busy, 0);
    check("reset out_pixel", out_pixel, 0);
    reset = 1'b0;
    cyc();

    // all zero -> 128
    fill_blk(0, 0);
    for (int i = 0; i < 64; i++) exp_pix[i] = 8'd128;
    run_block("zero", 1'b0, 1'b0);

    // DC 512 -> T[0][x]=180, pixels 191; in_valid junk while busy is ignored
    fill_blk(0, 512);
    for (int i = 0; i < 64; i++) exp_pix[i] = 8'd191;
    run_block("dc512", 1'b0, 1'b1);
    for (int x = 0; x < 8; x++)
      check($sformatf("dc512 T[0][%0d]", x), $signed(dut.t_mem_q[x]), 180);

    // DC -2048 -> T[0][x]=-720, P'=-253, clamped to 0
    fill_blk(0, -2048);
    for (int i = 0; i < 64; i++) exp_pix[i] = 8'd0;
    run_block("dcneg", 1'b0, 1'b0);
    for (int x = 0; x < 8; x++)
      check($sformatf("dcneg T[0][%0d]", x), $signed(dut.t_mem_q[x]), -720);

    // single AC X[0][1]=256
    fill_blk(1, 256);
    for (int i = 0; i < 64; i++) exp_pix[i] = ac_col[i % 8];
    run_block("ac01", 1'b0, 1'b0);

    // same block under random backpressure
    run_block("ac01_bp", 1'b1, 1'b0);

    // reset 200 cycles into ROW, then a fresh DC block
    fill_blk(0, -2048);
    blk[9] = 12'sd300;
    send_block("abort");
    repeat (200) cyc();
    check("abort busy in row", busy, 1);
    reset = 1'b1;
    #1;
    check("abort async in_ready", in_ready, 1);
    check("abort async busy", busy, 0);
    check("abort async out_valid", out_valid, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("abort in_ready after reset", in_ready, 1);
    fill_blk(0, 512);
    for (int i = 0; i < 64; i++) exp_pix[i] = 8'd191;
    run_block("post_abort", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
